gray_step_source: RTL

Sequential gray-code generator that sits directly upstream of the team's gray-to-binary converter stage. It keeps a binary up/down counter with enable and synchronous load, and presents each new count as a registered gray code. A valid/ready handshake carries the code downstream, with a sideband wrap flag. Every accepted back-to-back step changes exactly one output bit, except after a load.

---
 rtl/gray_step_source.sv | 102 ++++++++++
 1 files changed

// File: rtl/gray_step_source.sv
// Up/down binary counter presented downstream as a registered gray code over a
// valid/ready handshake, with a wrap sideband and synchronous load.
module gray_step_source #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_wrap
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] BIN_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] bin_step;
  logic             wrap_step;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Candidate next count and whether it crosses the modulus boundary.
  always_comb begin
    bin_step  = up_dn ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
    wrap_step = up_dn ? (bin == BIN_MAX) : (bin == '0);
  end

  // Next state / next registered outputs; load overrides any step or hold.
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin;
    gray_nxt  = gray_out;
    wrap_nxt  = out_wrap;
    if (load) begin
      state_nxt = PRESENT;
      bin_nxt   = load_bin;
      gray_nxt  = to_gray(load_bin);
      wrap_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state_nxt = PRESENT;
            bin_nxt   = bin_step;
            gray_nxt  = to_gray(bin_step);
            wrap_nxt  = wrap_step;
          end
        end
        PRESENT: begin
          // Stalled codes hold; en is dropped rather than queued.
          if (out_ready) begin
            if (en) begin
              bin_nxt  = bin_step;
              gray_nxt = to_gray(bin_step);
              wrap_nxt = wrap_step;
            end else begin
              state_nxt = IDLE;
              wrap_nxt  = 1'b0;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          wrap_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      gray_out <= '0;
      out_wrap <= 1'b0;
    end else begin
      state    <= state_nxt;
      bin      <= bin_nxt;
      gray_out <= gray_nxt;
      out_wrap <= wrap_nxt;
    end
  end

  assign out_valid = (state == PRESENT);

endmodule
